// File: rtl/regfile_mp.sv
// Multi-port register file: NRD registered read ports with write bypass, two write ports, post-reset clear sequencer.
// Optional parity storage and per-port perr output when REGFILE_PARITY_EN is defined.
module regfile_mp #(
  parameter int unsigned DW       = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              we0,
  input  logic [AW-1:0]     waddr0,
  input  logic [DW-1:0]     wdata0,
  input  logic              we1,
  input  logic [AW-1:0]     waddr1,
  input  logic [DW-1:0]     wdata1,
  input  logic [NRD-1:0]    re,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*DW-1:0] rdata
`ifdef REGFILE_PARITY_EN
  ,
  output logic [NRD-1:0]    perr
`endif
);

`ifdef REGFILE_PARITY_EN
  localparam int unsigned EW = DW + 1;
`else
  localparam int unsigned EW = DW;
`endif

  if (DEPTH != (32'd1 << AW) || AW < 1) begin : g_bad_depth
    $error("regfile_mp: DEPTH must equal 2**AW and be at least 2");
  end
  if (NRD < 1 || NRD > 4) begin : g_bad_nrd
    $error("regfile_mp: NRD must be in 1..4");
  end

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t            state_q;
  logic [AW-1:0]     cnt_q;
  logic              ready_q;
  logic [EW-1:0]     mem_q [DEPTH];
  logic [NRD*DW-1:0] rdata_d, rdata_q;
  logic              wr0_ok_c, wr1_ok_c;
  logic [AW-1:0]     ra;
  logic [EW-1:0]     ent;
`ifdef REGFILE_PARITY_EN
  logic [NRD-1:0]    perr_d, perr_q;
`endif

  function automatic logic [EW-1:0] encode(input logic [DW-1:0] d);
`ifdef REGFILE_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  // Clear sequencer: one entry per cycle, then READY until the next reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else if (state_q == S_CLEAR) begin
      cnt_q <= cnt_q + AW'(1);
      if (cnt_q == AW'(DEPTH - 1)) begin
        state_q <= S_READY;
        ready_q <= 1'b1;
      end
    end
  end

  assign wr0_ok_c = we0 && !(ZERO_REG != 0 && waddr0 == '0);
  assign wr1_ok_c = we1 && !(ZERO_REG != 0 && waddr1 == '0);

  // Array is left untouched while reset is asserted; port 1 wins on equal addresses
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state_q == S_CLEAR) begin
        mem_q[cnt_q] <= '0;
      end else begin
        if (wr0_ok_c) mem_q[waddr0] <= encode(wdata0);
        if (wr1_ok_c) mem_q[waddr1] <= encode(wdata1);
      end
    end
  end

  // Read mux: zero register, then port 1 bypass, then port 0 bypass, then array
  always_comb begin
    rdata_d = '0;
    ra      = '0;
    ent     = '0;
`ifdef REGFILE_PARITY_EN
    perr_d  = '0;
`endif
    for (int i = 0; i < NRD; i++) begin
      ra = raddr[i*AW +: AW];
      if (state_q == S_READY && re[i] && !(ZERO_REG != 0 && ra == '0)) begin
        if (we1 && waddr1 == ra) begin
          rdata_d[i*DW +: DW] = wdata1;
        end else if (we0 && waddr0 == ra) begin
          rdata_d[i*DW +: DW] = wdata0;
        end else begin
          ent = mem_q[ra];
          rdata_d[i*DW +: DW] = ent[DW-1:0];
`ifdef REGFILE_PARITY_EN
          perr_d[i] = ^ent;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= '0;
`ifdef REGFILE_PARITY_EN
      perr_q  <= '0;
`endif
    end else begin
      rdata_q <= rdata_d;
`ifdef REGFILE_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign ready = ready_q;
  assign rdata = rdata_q;
`ifdef REGFILE_PARITY_EN
  assign perr  = perr_q;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: instance A has ZERO_REG=1, instance B has ZERO_REG=0, shared stimulus.
module tb_regfile_mp;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned NRD = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              we0, we1;
  logic [AW-1:0]     waddr0, waddr1;
  logic [DW-1:0]     wdata0, wdata1;
  logic [NRD-1:0]    re;
  logic [NRD*AW-1:0] raddr;
  logic              ready_a, ready_b;
  logic [NRD*DW-1:0] rdata_a, rdata_b;
`ifdef REGFILE_PARITY_EN
  logic [NRD-1:0]    perr_a, perr_b;
`endif

  regfile_mp #(.DW(DW), .DEPTH(32), .AW(AW), .NRD(NRD), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst(rst), .ready(ready_a),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .re(re), .raddr(raddr), .rdata(rdata_a)
`ifdef REGFILE_PARITY_EN
    , .perr(perr_a)
`endif
  );

  regfile_mp #(.DW(DW), .DEPTH(32), .AW(AW), .NRD(NRD), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst(rst), .ready(ready_b),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .re(re), .raddr(raddr), .rdata(rdata_b)
`ifdef REGFILE_PARITY_EN
    , .perr(perr_b)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  pa;
    logic [1:0]  pb;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic chk_now = 1'b0;
  logic chk_q   = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: one expected entry per clock edge that had a checked read issued
  always @(posedge clk) chk_q <= chk_now;

  always @(negedge clk) begin
    if (chk_q) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: got empty queue expected an entry");
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.nm, ".rdata_a"}, rdata_a, mon_e.a);
        check({mon_e.nm, ".rdata_b"}, rdata_b, mon_e.b);
`ifdef REGFILE_PARITY_EN
        check({mon_e.nm, ".perr_a"}, 64'(perr_a), 64'(mon_e.pa));
        check({mon_e.nm, ".perr_b"}, 64'(perr_b), 64'(mon_e.pb));
`endif
      end
    end
  end

  task automatic push(input string nm, input logic [63:0] ea, input logic [63:0] eb,
                      input logic [1:0] pa, input logic [1:0] pb);
    exp_t e;
    e.nm = nm; e.a = ea; e.b = eb; e.pa = pa; e.pb = pb;
    sb.push_back(e);
    chk_now = 1'b1;
  endtask

  // Called at posedge+1; drives one cycle of stimulus and queues the expected read result
  task automatic vec(input string nm,
                     input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                     input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                     input logic [1:0] r, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                     input logic [63:0] ea, input logic [63:0] eb,
                     input logic [1:0] pa, input logic [1:0] pb);
    we0 = w0; waddr0 = a0; wdata0 = d0;
    we1 = w1; waddr1 = a1; wdata1 = d1;
    re = r; raddr = {ra1, ra0};
    push(nm, ea, eb, pa, pb);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    we0 = 1'b0; we1 = 1'b0; re = '0; chk_now = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string nm, input bit push_zero);
    int n;
    n = 0;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (ready_a) break;
      if (push_zero) push({nm, "_clr"}, 64'd0, 64'd0, 2'b00, 2'b00);
    end
    we0 = 1'b0; we1 = 1'b0; re = '0; chk_now = 1'b0;
    check({nm, "_cycles"}, 64'(n), 64'd32);
    check({nm, "_ready_b"}, 64'(ready_b), 64'd1);
  endtask

  initial begin
    rst = 1'b0;
    we0 = 1'b0; waddr0 = '0; wdata0 = '0;
    we1 = 1'b0; waddr1 = '0; wdata1 = '0;
    re = '0; raddr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready_a", 64'(ready_a), 64'd0);
    check("rst_rdata_a", rdata_a, 64'd0);
    check("rst_rdata_b", rdata_b, 64'd0);

    // Clear sequence with writes and reads attempted throughout; all must be ignored
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hAAAA5555;
    we1 = 1'b1; waddr1 = 5'd6; wdata1 = 32'h5555AAAA;
    re = 2'b11; raddr = {5'd6, 5'd5};
    push("clr_first", 64'd0, 64'd0, 2'b00, 2'b00);
    rst = 1'b1;
    wait_ready("clear1", 1'b1);
    vec("post_clr_r5_r6", 0, 0, 0, 0, 0, 0, 2'b11, 5'd5, 5'd6, 64'd0, 64'd0, 2'b00, 2'b00);
    idle(2);

    // Reset in the middle of the clear sequence restarts the count
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("midclr_not_ready", 64'(ready_a), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    wait_ready("midclr", 1'b0);

    vec("wr_r3", 1, 5'd3, 32'hDEADBEEF, 0, 0, 0, 2'b00, 5'd3, 5'd3,
        64'd0, 64'd0, 2'b00, 2'b00);
    vec("rd_r3", 0, 0, 0, 0, 0, 0, 2'b01, 5'd3, 5'd3,
        {32'd0, 32'hDEADBEEF}, {32'd0, 32'hDEADBEEF}, 2'b00, 2'b00);
    vec("collide_r7", 1, 5'd7, 32'h11111111, 1, 5'd7, 32'h22222222, 2'b11, 5'd7, 5'd7,
        {32'h22222222, 32'h22222222}, {32'h22222222, 32'h22222222}, 2'b00, 2'b00);
    vec("rd_r7_r3", 0, 0, 0, 0, 0, 0, 2'b11, 5'd7, 5'd3,
        {32'hDEADBEEF, 32'h22222222}, {32'hDEADBEEF, 32'h22222222}, 2'b00, 2'b00);
    vec("zero_byp", 1, 5'd0, 32'hFFFFFFFF, 0, 0, 0, 2'b01, 5'd0, 5'd0,
        64'd0, {32'd0, 32'hFFFFFFFF}, 2'b00, 2'b00);
    vec("zero_rd", 0, 0, 0, 0, 0, 0, 2'b11, 5'd0, 5'd0,
        64'd0, {32'hFFFFFFFF, 32'hFFFFFFFF}, 2'b00, 2'b00);
    vec("byp0_port1", 1, 5'd10, 32'h12345678, 0, 0, 0, 2'b10, 5'd10, 5'd10,
        {32'h12345678, 32'd0}, {32'h12345678, 32'd0}, 2'b00, 2'b00);
    vec("byp_both", 1, 5'd12, 32'hA5A5A5A5, 1, 5'd13, 32'h5A5A5A5A, 2'b11, 5'd12, 5'd13,
        {32'h5A5A5A5A, 32'hA5A5A5A5}, {32'h5A5A5A5A, 32'hA5A5A5A5}, 2'b00, 2'b00);
    vec("rd_r12_r13", 0, 0, 0, 0, 0, 0, 2'b11, 5'd12, 5'd13,
        {32'h5A5A5A5A, 32'hA5A5A5A5}, {32'h5A5A5A5A, 32'hA5A5A5A5}, 2'b00, 2'b00);
    vec("wr1_r3", 0, 0, 0, 1, 5'd3, 32'hCAFEF00D, 2'b11, 5'd3, 5'd10,
        {32'h12345678, 32'hCAFEF00D}, {32'h12345678, 32'hCAFEF00D}, 2'b00, 2'b00);
    vec("wr_both_r0", 1, 5'd0, 32'h00000066, 1, 5'd0, 32'h00000055, 2'b10, 5'd0, 5'd0,
        64'd0, {32'h00000055, 32'd0}, 2'b00, 2'b00);
    vec("rd_r0_r3", 0, 0, 0, 0, 0, 0, 2'b11, 5'd0, 5'd3,
        {32'hCAFEF00D, 32'd0}, {32'hCAFEF00D, 32'h00000055}, 2'b00, 2'b00);
    vec("wr_r20_r21", 1, 5'd20, 32'h01010101, 1, 5'd21, 32'h02020202, 2'b00, 5'd20, 5'd21,
        64'd0, 64'd0, 2'b00, 2'b00);
    vec("rd_r20_r21", 0, 0, 0, 0, 0, 0, 2'b11, 5'd20, 5'd21,
        {32'h02020202, 32'h01010101}, {32'h02020202, 32'h01010101}, 2'b00, 2'b00);
    vec("re_off", 0, 0, 0, 0, 0, 0, 2'b00, 5'd20, 5'd21,
        64'd0, 64'd0, 2'b00, 2'b00);

`ifdef REGFILE_PARITY_EN
    vec("par_wr_r9", 1, 5'd9, 32'h0000000F, 0, 0, 0, 2'b00, 5'd9, 5'd9,
        64'd0, 64'd0, 2'b00, 2'b00);
    dut_a.mem_q[9] = dut_a.mem_q[9] ^ 33'd1;
    dut_b.mem_q[9] = dut_b.mem_q[9] ^ 33'd1;
    vec("par_flip_rd", 0, 0, 0, 0, 0, 0, 2'b01, 5'd9, 5'd9,
        {32'd0, 32'h0000000E}, {32'd0, 32'h0000000E}, 2'b01, 2'b01);
    vec("par_byp", 1, 5'd9, 32'h0000000F, 0, 0, 0, 2'b01, 5'd9, 5'd9,
        {32'd0, 32'h0000000F}, {32'd0, 32'h0000000F}, 2'b00, 2'b00);
    vec("par_rd_ok", 0, 0, 0, 0, 0, 0, 2'b11, 5'd9, 5'd3,
        {32'hCAFEF00D, 32'h0000000F}, {32'hCAFEF00D, 32'h0000000F}, 2'b00, 2'b00);
`endif

    idle(3);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
